// File: rtl/jk_reg_bank.sv
// Bank of WIDTH JK cells sharing one clock and async reset; the same cells also serve as an
// up-counter (T-chain) or a parallel-load register. Optional toggle-event counter: JK_BANK_EVT_CNT_EN.
module jk_reg_bank #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             changed,
  output logic             wrap,
  output logic [CNT_W-1:0] evt_cnt
);

  localparam logic [1:0] MODE_JK   = 2'b00;
  localparam logic [1:0] MODE_CNT  = 2'b01;
  localparam logic [1:0] MODE_LOAD = 2'b10;

  logic [WIDTH-1:0] r_q;
  logic             r_changed;
  logic             r_wrap;
  logic [WIDTH-1:0] w_next_q;
  logic [WIDTH-1:0] w_jk_q;
  logic [WIDTH-1:0] w_tog;
  logic             w_wrap_nxt;
  logic             w_changed_nxt;

  // Bit i toggles when every lower bit is 1; all bits see the same edge.
  function automatic logic [WIDTH-1:0] count_toggles(input logic [WIDTH-1:0] q_in);
    logic [WIDTH-1:0] one_v;
    logic [WIDTH-1:0] low_mask;
    logic [WIDTH-1:0] tog;
    one_v = {{(WIDTH-1){1'b0}}, 1'b1};
    tog   = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      low_mask = (one_v << i) - one_v;
      tog[i]   = &(q_in | ~low_mask);
    end
    return tog;
  endfunction

  assign w_jk_q = (j & ~r_q) | (~k & r_q);
  assign w_tog  = count_toggles(r_q);

  // Next-state selection by mode; disabled cycles and mode 11 hold q.
  always_comb begin
    w_next_q   = r_q;
    w_wrap_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_JK:   w_next_q = w_jk_q;
        MODE_CNT: begin
          w_next_q   = r_q ^ w_tog;
          w_wrap_nxt = &r_q;
        end
        MODE_LOAD: w_next_q = d;
        default:   w_next_q = r_q;
      endcase
    end else begin
      w_next_q   = r_q;
      w_wrap_nxt = 1'b0;
    end
  end

  assign w_changed_nxt = (w_next_q != r_q);

  // State and status flag registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= RST_VAL;
      r_changed <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_q       <= w_next_q;
      r_changed <= w_changed_nxt;
      r_wrap    <= w_wrap_nxt;
    end
  end

`ifdef JK_BANK_EVT_CNT_EN
  logic [CNT_W-1:0] r_evt_cnt;

  // Saturating count of edges that changed q; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_evt_cnt <= {CNT_W{1'b0}};
    end else if (w_changed_nxt && (r_evt_cnt != {CNT_W{1'b1}})) begin
      r_evt_cnt <= r_evt_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_evt_cnt <= r_evt_cnt;
    end
  end

  assign evt_cnt = r_evt_cnt;
`else
  assign evt_cnt = {CNT_W{1'b0}};
`endif

  assign q       = r_q;
  assign qn      = ~r_q;
  assign changed = r_changed;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Scoreboard bench for jk_reg_bank (WIDTH=4, RST_VAL=0101, CNT_W=2): stimulus pushes expected
// state after each edge, a negedge monitor pops and compares.
module tb_jk_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [3:0] j, k, d;
  logic [3:0] q, qn;
  logic       changed, wrap;
  logic [1:0] evt_cnt;

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] qn;
    logic       ch;
    logic       wr;
    logic [1:0] ev;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_vec = 0;
  int    n_bad = 0;
  logic [1:0] exp_evt = 2'd0;

  jk_reg_bank #(.WIDTH(4), .RST_VAL(4'b0101), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .j(j), .k(k), .d(d),
    .q(q), .qn(qn), .changed(changed), .wrap(wrap), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic push(input string nm, input logic [3:0] eq, input logic ech, input logic ewr);
    exp_t e;
`ifdef JK_BANK_EVT_CNT_EN
    if (ech && exp_evt != 2'd3) exp_evt = exp_evt + 2'd1;
`endif
    e.q = eq; e.qn = ~eq; e.ch = ech; e.wr = ewr; e.ev = exp_evt;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step(input string nm, input logic ien, input logic [1:0] imode,
                      input logic [3:0] ij, input logic [3:0] ik, input logic [3:0] id,
                      input logic [3:0] eq, input logic ech, input logic ewr);
    en = ien; mode = imode; j = ij; k = ik; d = id;
    @(posedge clk);
    push(nm, eq, ech, ewr);
    #1;
  endtask

  // Reset asserted between edges, checked before the next edge, then held across one edge.
  task automatic do_reset(input string nm);
    en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    en = 1'b1;
    exp_evt = 2'd0;
    push({nm, "_async"}, 4'b0101, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    push({nm, "_held"}, 4'b0101, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: one expected record per negedge while the scoreboard holds entries.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      n_vec++;
      if ({q, qn, changed, wrap, evt_cnt} !== {e.q, e.qn, e.ch, e.wr, e.ev}) begin
        n_bad++;
        $display("FAIL %s: got q=%b qn=%b ch=%b wr=%b ev=%0d, want q=%b qn=%b ch=%b wr=%b ev=%0d",
                 nm, q, qn, changed, wrap, evt_cnt, e.q, e.qn, e.ch, e.wr, e.ev);
      end
    end
  end

  initial begin
    reset = 1'b0; en = 1'b0; mode = 2'b00; j = 4'b0000; k = 4'b0000; d = 4'b0000;
    do_reset("rst0");
    step("jk_mix",    1'b1, 2'b00, 4'b1100, 4'b1010, 4'b0000, 4'b1101, 1'b1, 1'b0);
    step("load1110",  1'b1, 2'b10, 4'b0000, 4'b0000, 4'b1110, 4'b1110, 1'b1, 1'b0);
    step("cnt1111",   1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0);
    step("cnt_wrap",  1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    step("cnt0001",   1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 1'b1, 1'b0);
    step("en0_a",     1'b0, 2'b01, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step("en0_b",     1'b0, 2'b01, 4'b1111, 4'b1111, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step("load_same", 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0001, 4'b0001, 1'b0, 1'b0);
    step("jk_hold",   1'b1, 2'b00, 4'b0000, 4'b0000, 4'b1010, 4'b0001, 1'b0, 1'b0);
    step("mode11",    1'b1, 2'b11, 4'b1111, 4'b1111, 4'b1111, 4'b0001, 1'b0, 1'b0);
    step("jk_reset",  1'b1, 2'b00, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b0);
    step("load0110",  1'b1, 2'b10, 4'b0000, 4'b0000, 4'b0110, 4'b0110, 1'b1, 1'b0);
    step("cnt0111",   1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 1'b1, 1'b0);
    do_reset("rst_cnt");
    step("rc0110",    1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0110, 1'b1, 1'b0);
    step("rc0111",    1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0111, 1'b1, 1'b0);
    step("rc1000",    1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 1'b1, 1'b0);
    step("rc1001",    1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b1001, 1'b1, 1'b0);
    step("rc1010",    1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b1010, 1'b1, 1'b0);
    step("jk_togall", 1'b1, 2'b00, 4'b1111, 4'b1111, 4'b0000, 4'b0101, 1'b1, 1'b0);
    step("load1111",  1'b1, 2'b10, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0);
    step("jk_nowrap", 1'b1, 2'b00, 4'b0000, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0);
    step("ld_nowrap", 1'b1, 2'b10, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 1'b1, 1'b0);
    step("cnt_wrap2", 1'b1, 2'b01, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    en = 1'b0;
    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
